// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: sequential reader for the weight SRAM that streams
// each 100-bit word (25 x 4-bit weights) to the PE array weight loader.
// Ports:
//   clk, srst                  clock, synchronous active-high reset
//   start, base_addr, word_cnt request (sampled in IDLE only)
//   busy, done                 status (done is a one-cycle pulse)
//   sram_csb, sram_raddr       registered SRAM read request (csb low = read)
//   sram_rdata                 SRAM read data, valid the cycle after csb low
//   w_valid, w_ready           output stream handshake
//   w_data, w_last             weight word and end-of-request marker
module weight_fetch_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 100,
  parameter int CNT_WIDTH  = 15,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_ret;
  logic                  r_csb;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_mlast [BUF_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [OW-1:0]         r_occ;

  // Park slot: catches a returning word that finds the FIFO full and
  // not draining, so a read already committed is never dropped.
  logic                  r_parked;
  logic [DATA_WIDTH-1:0] r_park_data;
  logic                  r_park_last;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_pend;
  logic                  w_park;
  logic                  w_push;
  logic                  w_ret_last;
  logic                  w_push_last;
  logic [DATA_WIDTH-1:0] w_push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start
                    && (word_cnt != '0);
  assign w_pop    = w_valid && w_ready;
  assign w_full   = (r_occ == OW'(BUF_DEPTH));
  assign w_pend   = r_inflight | r_parked;

  assign w_ret_last  = (r_ret == r_cnt - CNT_WIDTH'(1));
  assign w_park      = r_inflight && w_full && !w_pop;
  assign w_push      = r_parked ? w_pop : (r_inflight && !w_park);
  assign w_push_data = r_parked ? r_park_data : sram_rdata;
  assign w_push_last = r_parked ? r_park_last : w_ret_last;

  always_ff @(posedge clk) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (word_cnt == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        // Credit on next-cycle occupancy: pending words vs free slots.
        w_issue = (32'(r_occ) + 32'(w_pend))
                  < (32'(BUF_DEPTH) + 32'(w_pop));
        if (w_issue && (r_issued == r_cnt - CNT_WIDTH'(1)))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_issued   <= '0;
      r_ret      <= '0;
      r_csb      <= 1'b1;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base   <= base_addr;
        r_cnt    <= word_cnt;
        r_issued <= '0;
        r_ret    <= '0;
      end
      r_csb      <= !w_issue;
      r_inflight <= !r_csb;
      if (w_issue) begin
        r_raddr  <= r_base + ADDR_WIDTH'(r_issued);
        r_issued <= r_issued + CNT_WIDTH'(1);
      end
      if (r_inflight)
        r_ret <= r_ret + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_parked    <= 1'b0;
      r_park_data <= '0;
      r_park_last <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i]   <= '0;
        r_mlast[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr]   <= w_push_data;
        r_mlast[r_wptr] <= w_push_last;
        r_wptr          <= ptr_inc(r_wptr);
      end
      if (w_pop)
        r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)
        r_occ <= r_occ + OW'(1);
      else if (!w_push && w_pop)
        r_occ <= r_occ - OW'(1);
      if (w_park) begin
        r_parked    <= 1'b1;
        r_park_data <= sram_rdata;
        r_park_last <= w_ret_last;
      end else if (r_parked && w_pop) begin
        r_parked <= 1'b0;
      end
    end
  end

  assign busy       = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign sram_csb   = r_csb;
  assign sram_raddr = r_raddr;
  assign w_valid    = (r_occ != '0);
  assign w_data     = r_mem[r_rptr];
  assign w_last     = r_mlast[r_rptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (srst)
    !(w_push && w_full && !w_pop));
  a_no_double_park: assert property (@(posedge clk) disable iff (srst)
    !(w_park && r_parked));

endmodule
